// File: rtl/mips_pkg.sv
// Shared MIPS definitions: opcode constants, fetch FSM state encoding and the
// default reset PC used by the instruction-fetch stage.
package mips_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

  typedef enum logic {
    S_REQ  = 1'b0,
    S_HOLD = 1'b1
  } fetch_state_e;

  function automatic logic [5:0] opcode_of(input logic [31:0] word);
    return word[31:26];
  endfunction

endpackage

// File: rtl/next_pc.sv
// Next-PC selection for the fetch stage: jump, taken branch or sequential.
// Build option FETCH_BNE_EN makes bne take its branch when zero is clear.
module next_pc
  import mips_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic [ADDR_W-1:0] i_pc_plus4,
  input  logic [31:0]       i_instr,
  input  logic              i_branch,
  input  logic              i_jump,
  input  logic              i_zero,
  output logic [ADDR_W-1:0] o_target
);

  logic [ADDR_W-1:0] w_jump_target;
  logic [ADDR_W-1:0] w_branch_target;
  logic              w_taken;

  // Jump keeps the top four bits of the sequential address (same 256 MB region).
  assign w_jump_target   = {i_pc_plus4[ADDR_W-1:28], i_instr[25:0], 2'b00};
  assign w_branch_target = i_pc_plus4 + {{(ADDR_W-18){i_instr[15]}}, i_instr[15:0], 2'b00};

`ifdef FETCH_BNE_EN
  assign w_taken = i_branch && ((opcode_of(i_instr) == OP_BNE) ? !i_zero : i_zero);
`else
  logic w_unused_opcode;
  assign w_unused_opcode = ^i_instr[31:26];
  assign w_taken         = i_branch && i_zero;
`endif

  always_comb begin
    o_target = i_pc_plus4;
    if (i_jump) begin
      o_target = w_jump_target;
    end else if (w_taken) begin
      o_target = w_branch_target;
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// MIPS instruction-fetch stage: PC, req/ack fetch FSM and instruction register.
// Optional build macro FETCH_BNE_EN enables bne handling inside next_pc.
module fetch_unit
  import mips_pkg::*;
#(
  parameter int                ADDR_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(RESET_PC_DEFAULT)
) (
  input  logic              clk,
  input  logic              reset,
  output logic              imemReq,
  output logic [ADDR_W-1:0] imemAddr,
  input  logic              imemAck,
  input  logic [31:0]       imemData,
  output logic [31:0]       instr,
  output logic [5:0]        opCode,
  output logic              instrValid,
  output logic [ADDR_W-1:0] pcOut,
  output logic [ADDR_W-1:0] pcPlus4,
  input  logic              stall,
  input  logic              branch,
  input  logic              jump,
  input  logic              zero
);

  fetch_state_e      r_state;
  fetch_state_e      w_state_next;
  logic [ADDR_W-1:0] r_pc;
  logic [ADDR_W-1:0] r_pc_out;
  logic [31:0]       r_instr;
  logic              r_instr_valid;
  logic              w_load;
  logic              w_retire;
  logic [ADDR_W-1:0] w_pc_plus4;
  logic [ADDR_W-1:0] w_next_pc;

  assign w_pc_plus4 = r_pc_out + ADDR_W'(4);

  next_pc #(
    .ADDR_W(ADDR_W)
  ) u_next_pc (
    .i_pc_plus4(w_pc_plus4),
    .i_instr   (r_instr),
    .i_branch  (branch),
    .i_jump    (jump),
    .i_zero    (zero),
    .o_target  (w_next_pc)
  );

  // NOTE: every always_comb output gets a default first so no path infers a latch.
  always_comb begin
    w_state_next = r_state;
    w_load       = 1'b0;
    w_retire     = 1'b0;
    case (r_state)
      S_REQ: begin
        if (imemAck) begin
          w_load       = 1'b1;
          w_state_next = S_HOLD;
        end
      end
      S_HOLD: begin
        if (!stall) begin
          w_retire     = 1'b1;
          w_state_next = S_REQ;
        end
      end
      default: w_state_next = S_REQ;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state       <= S_REQ;
      r_pc          <= RESET_PC;
      r_pc_out      <= RESET_PC;
      r_instr       <= '0;
      r_instr_valid <= 1'b0;
    end else begin
      r_state <= w_state_next;
      if (w_load) begin
        r_instr       <= imemData;
        r_pc_out      <= r_pc;
        r_instr_valid <= 1'b1;
      end
      if (w_retire) begin
        r_pc          <= w_next_pc;
        r_instr_valid <= 1'b0;
      end
    end
  end

  assign imemReq    = (r_state == S_REQ) && !reset;
  assign imemAddr   = r_pc;
  assign instr      = r_instr;
  assign opCode     = opcode_of(r_instr);
  assign instrValid = r_instr_valid;
  assign pcOut      = r_pc_out;
  assign pcPlus4    = w_pc_plus4;

endmodule
